// File: rtl/process_stream_ctrl.sv
// process_stream_ctrl: buffers strobed pin-side samples in a small FIFO and
// runs each one through an external kernel using valid/ready handshakes:
// data + start token go out, result + end token come back, and the result is
// published on sample_out with a one-cycle out_strobe.
module process_stream_ctrl #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] sample_in,
    input  logic       sample_strobe,
    input  logic       clear_flags,
    output logic [7:0] sample_out,
    output logic       out_strobe,
    output logic       busy,
    output logic       overflow,
    output logic [7:0] proc_count,
    output logic [7:0] k_in0,
    output logic       k_in0_valid,
    input  logic       k_in0_ready,
    output logic       k_start_valid,
    input  logic       k_start_ready,
    input  logic [7:0] k_out0,
    input  logic       k_out0_valid,
    output logic       k_out0_ready,
    input  logic       k_end_valid,
    output logic       k_end_ready
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push;
    logic             pop;
    logic             drop;

    logic       in0_done;
    logic       start_done;
    logic       out0_done;
    logic       end_done;
    logic [7:0] result;

    logic in0_xfer;
    logic start_xfer;
    logic out0_xfer;
    logic end_xfer;
    logic issue_done;
    logic wait_done;

    assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));
    assign fifo_empty = (count == '0);
    // A pop on the same edge frees the slot the push needs.
    assign pop        = in0_xfer;
    assign push       = sample_strobe && (!fifo_full || pop);
    assign drop       = sample_strobe && !push;
    assign k_in0      = mem[rd_ptr];
    assign busy       = (state != IDLE) || !fifo_empty;

    // Sample storage: written on every accepted push.
    // NOTE: the data array carries no reset; pointers and count alone define
    // what is valid, and leaving memories unreset lets them map onto RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= sample_in;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state, handshake outputs and transfer detection.
    // NOTE: every output of this block gets a default first, so no path
    // through the case statement can leave a value held (no latch).
    always_comb begin
        state_next    = state;
        k_in0_valid   = 1'b0;
        k_start_valid = 1'b0;
        k_out0_ready  = 1'b0;
        k_end_ready   = 1'b0;
        in0_xfer      = 1'b0;
        start_xfer    = 1'b0;
        out0_xfer     = 1'b0;
        end_xfer      = 1'b0;
        issue_done    = 1'b0;
        wait_done     = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) state_next = ISSUE;
            end
            ISSUE: begin
                k_in0_valid   = !in0_done;
                k_start_valid = !start_done;
                in0_xfer      = k_in0_valid && k_in0_ready;
                start_xfer    = k_start_valid && k_start_ready;
                issue_done    = (in0_done || in0_xfer) && (start_done || start_xfer);
                if (issue_done) state_next = WAIT;
            end
            WAIT: begin
                k_out0_ready = !out0_done;
                k_end_ready  = !end_done;
                out0_xfer    = k_out0_valid && k_out0_ready;
                end_xfer     = k_end_valid && k_end_ready;
                wait_done    = (out0_done || out0_xfer) && (end_done || end_xfer);
                if (wait_done) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Per-transaction done flags and kernel result capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            in0_done   <= 1'b0;
            start_done <= 1'b0;
            out0_done  <= 1'b0;
            end_done   <= 1'b0;
            result     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        in0_done   <= 1'b0;
                        start_done <= 1'b0;
                    end
                end
                ISSUE: begin
                    if (in0_xfer)   in0_done   <= 1'b1;
                    if (start_xfer) start_done <= 1'b1;
                    if (issue_done) begin
                        out0_done <= 1'b0;
                        end_done  <= 1'b0;
                    end
                end
                WAIT: begin
                    if (out0_xfer) begin
                        out0_done <= 1'b1;
                        result    <= k_out0;
                    end
                    if (end_xfer) end_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Published result, completion pulse, counter and sticky overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            sample_out <= '0;
            out_strobe <= 1'b0;
            proc_count <= '0;
            overflow   <= 1'b0;
        end else begin
            out_strobe <= wait_done;
            if (wait_done) begin
                // A result arriving on the completing edge bypasses the capture register.
                sample_out <= out0_xfer ? k_out0 : result;
                proc_count <= proc_count + 8'd1;
            end
            if (drop)             overflow <= 1'b1;
            else if (clear_flags) overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_process_stream_ctrl.sv
// Self-checking bench for process_stream_ctrl: a behavioural kernel with
// adjustable stalls/delays returns in0 ^ 0x7A; expected results are queued
// when a sample is strobed and compared when out_strobe fires.
module tb_process_stream_ctrl;

    logic       clk;
    logic       rst;
    logic [7:0] sample_in;
    logic       sample_strobe;
    logic       clear_flags;
    logic [7:0] sample_out;
    logic       out_strobe;
    logic       busy;
    logic       overflow;
    logic [7:0] proc_count;
    logic [7:0] k_in0;
    logic       k_in0_valid;
    logic       k_in0_ready;
    logic       k_start_valid;
    logic       k_start_ready;
    logic [7:0] k_out0;
    logic       k_out0_valid;
    logic       k_out0_ready;
    logic       k_end_valid;
    logic       k_end_ready;

    process_stream_ctrl #(.FIFO_DEPTH(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .sample_in     (sample_in),
        .sample_strobe (sample_strobe),
        .clear_flags   (clear_flags),
        .sample_out    (sample_out),
        .out_strobe    (out_strobe),
        .busy          (busy),
        .overflow      (overflow),
        .proc_count    (proc_count),
        .k_in0         (k_in0),
        .k_in0_valid   (k_in0_valid),
        .k_in0_ready   (k_in0_ready),
        .k_start_valid (k_start_valid),
        .k_start_ready (k_start_ready),
        .k_out0        (k_out0),
        .k_out0_valid  (k_out0_valid),
        .k_out0_ready  (k_out0_ready),
        .k_end_valid   (k_end_valid),
        .k_end_ready   (k_end_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] exp_q[$];
    int strobe_cnt = 0;
    int done_cnt   = 0;

    // Kernel model knobs and transfer counters.
    bit   stall_in0   = 1'b0;
    int   start_delay = 0;
    int   out_delay   = 0;
    int   end_delay   = 0;
    int   n_in0 = 0, n_start = 0, n_out = 0, n_end = 0;

    logic [7:0] k_data, x_data;
    bit   got_in0, got_start, got_out, got_end;
    bit   in0_x, st_x, o_x, e_x;
    bit   kphase;
    int   kcnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Behavioural kernel: transfers decided at one negedge take effect at the
    // following posedge and are accounted for at the next negedge.
    always @(negedge clk) begin
        if (rst) begin
            k_in0_ready   = 1'b0;
            k_start_ready = 1'b0;
            k_out0_valid  = 1'b0;
            k_end_valid   = 1'b0;
            k_out0        = 8'h00;
            got_in0 = 0; got_start = 0; got_out = 0; got_end = 0;
            in0_x = 0; st_x = 0; o_x = 0; e_x = 0;
            kphase = 0; kcnt = 0;
        end else begin
            if (in0_x) begin k_data = x_data; got_in0 = 1; n_in0++; end
            if (st_x)  begin got_start = 1; n_start++; end
            if (o_x)   begin got_out = 1; n_out++; end
            if (e_x)   begin got_end = 1; n_end++; end
            if (!kphase) begin
                if (got_in0) kcnt++;
                if (got_in0 && got_start) begin
                    kphase = 1; kcnt = 0; got_in0 = 0; got_start = 0;
                    k_in0_ready = 1'b0; k_start_ready = 1'b0;
                end else begin
                    k_in0_ready   = !got_in0 && !stall_in0;
                    k_start_ready = !got_start && (start_delay == 0 || (got_in0 && kcnt > start_delay));
                end
            end else begin
                kcnt++;
                if (got_out && got_end) begin
                    kphase = 0; kcnt = 0; got_out = 0; got_end = 0;
                    k_out0_valid  = 1'b0;
                    k_end_valid   = 1'b0;
                    k_in0_ready   = !stall_in0;
                    k_start_ready = (start_delay == 0);
                end else begin
                    if (!k_out0_valid) k_out0 = k_data ^ 8'h7A;
                    k_out0_valid = !got_out && (k_out0_valid || kcnt > out_delay);
                    k_end_valid  = !got_end && (k_end_valid || kcnt > out_delay + end_delay);
                end
            end
            in0_x  = k_in0_valid && k_in0_ready;
            x_data = k_in0;
            st_x   = k_start_valid && k_start_ready;
            o_x    = k_out0_valid && k_out0_ready;
            e_x    = k_end_valid && k_end_ready;
        end
    end

    // Output scoreboard: every out_strobe pops one expected result.
    always @(negedge clk) begin
        if (!rst && out_strobe) begin
            strobe_cnt++;
            done_cnt++;
            if (exp_q.size() == 0) check("sb_unexpected_out", 32'(exp_q.size()), 32'd1);
            else                   check("sb_data", sample_out, exp_q.pop_front());
            check("sb_proc_count", proc_count, done_cnt[7:0]);
        end
    end

    // Drive one strobe at the current negedge; returns one negedge later.
    task automatic push_sample(input logic [7:0] v, input bit accepted);
        sample_in     = v;
        sample_strobe = 1'b1;
        if (accepted) exp_q.push_back(v ^ 8'h7A);
        @(negedge clk);
        sample_strobe = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (!busy && exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        check({tag, "_drained"}, 32'(ok), 32'd1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_sample_out"}, sample_out, 8'h00);
        check({tag, "_out_strobe"}, out_strobe, 1'b0);
        check({tag, "_overflow"},   overflow, 1'b0);
        check({tag, "_proc_count"}, proc_count, 8'h00);
        check({tag, "_busy"},       busy, 1'b0);
        check({tag, "_in0_valid"},  k_in0_valid, 1'b0);
        check({tag, "_start_valid"}, k_start_valid, 1'b0);
        check({tag, "_out0_ready"}, k_out0_ready, 1'b0);
        check({tag, "_end_ready"},  k_end_ready, 1'b0);
    endtask

    // Input/kernel snapshot used for the skew test deltas.
    int s_in0, s_start, s_out, s_end, s_strobe;
    bit reached;

    initial begin
        rst = 1'b1;
        sample_in = 8'h00;
        sample_strobe = 1'b0;
        clear_flags = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_reset_values("rst");

        // Single sample with latency check.
        s_strobe = strobe_cnt;
        push_sample(8'h40, 1'b1);
        check("lat_n1_in0_valid", k_in0_valid, 1'b0);
        @(negedge clk);
        check("lat_n2_in0_valid", k_in0_valid, 1'b1);
        check("lat_n2_in0_data", k_in0, 8'h40);
        check("lat_n2_start_valid", k_start_valid, 1'b1);
        check("issue_out0_ready", k_out0_ready, 1'b0);
        check("issue_end_ready", k_end_ready, 1'b0);
        wait_idle("single");
        check("single_sample_out", sample_out, 8'h3A);
        check("single_proc_count", proc_count, 8'd1);
        check("single_strobes", 32'(strobe_cnt - s_strobe), 32'd1);

        // Handshake skew: late start_ready, late end_valid.
        start_delay = 5;
        end_delay   = 3;
        s_in0 = n_in0; s_start = n_start; s_out = n_out; s_end = n_end; s_strobe = strobe_cnt;
        push_sample(8'h55, 1'b1);
        wait_idle("skew");
        check("skew_in0_xfers",   32'(n_in0 - s_in0), 32'd1);
        check("skew_start_xfers", 32'(n_start - s_start), 32'd1);
        check("skew_out0_xfers",  32'(n_out - s_out), 32'd1);
        check("skew_end_xfers",   32'(n_end - s_end), 32'd1);
        check("skew_strobes",     32'(strobe_cnt - s_strobe), 32'd1);
        check("skew_sample_out",  sample_out, 8'h2F);
        check("skew_proc_count",  proc_count, 8'd2);
        start_delay = 0;
        end_delay   = 0;

        // Overflow with stalled kernel, set-over-clear priority, then clear.
        @(posedge clk);
        #1 stall_in0 = 1'b1;
        @(negedge clk);
        for (int i = 1; i <= 4; i++) push_sample(8'(i), 1'b1);
        check("ovf_before_drop", overflow, 1'b0);
        push_sample(8'h05, 1'b0);
        check("ovf_set", overflow, 1'b1);
        check("ovf_head", k_in0, 8'h01);
        clear_flags = 1'b1;
        push_sample(8'h06, 1'b0);
        clear_flags = 1'b0;
        check("ovf_set_priority", overflow, 1'b1);
        clear_flags = 1'b1;
        @(negedge clk);
        clear_flags = 1'b0;
        check("ovf_cleared", overflow, 1'b0);
        check("ovf_busy_stalled", busy, 1'b1);
        @(posedge clk);
        #1 stall_in0 = 1'b0;
        wait_idle("ovf");
        check("ovf_proc_count", proc_count, 8'd6);

        // Full FIFO, strobe on the same edge as the k_in0 pop.
        @(posedge clk);
        #1 stall_in0 = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 4; i++) push_sample(8'h10 + 8'(i), 1'b1);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1 stall_in0 = 1'b0;
        @(negedge clk);
        push_sample(8'h14, 1'b1);
        check("simul_overflow", overflow, 1'b0);
        push_sample(8'h99, 1'b0);
        check("simul_still_full", overflow, 1'b1);
        wait_idle("simul");
        check("simul_proc_count", proc_count, 8'd11);

        // Reset while out0 is pending.
        out_delay = 20;
        push_sample(8'h77, 1'b0);
        reached = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (k_out0_ready) begin
                reached = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("rstwait_reached_wait", 32'(reached), 32'd1);
        @(posedge clk);
        #1 rst = 1'b1;
        done_cnt = 0;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_reset_values("rstwait");
        out_delay = 0;
        push_sample(8'h21, 1'b1);
        wait_idle("post_rst");
        check("post_rst_sample_out", sample_out, 8'h5B);
        check("post_rst_proc_count", proc_count, 8'd1);

        // 255 more completions with random timing: counter wraps to 0.
        for (int i = 0; i < 255; i++) begin
            reached = 1'b0;
            for (int c = 0; c < 200; c++) begin
                if (exp_q.size() < 4) begin
                    reached = 1'b1;
                    break;
                end
                @(negedge clk);
            end
            if (!reached) check("wrap_space_timeout", 32'(reached), 32'd1);
            start_delay = $urandom_range(0, 2);
            out_delay   = $urandom_range(0, 2);
            end_delay   = $urandom_range(0, 2);
            push_sample(8'($urandom), 1'b1);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        wait_idle("wrap");
        check("wrap_proc_count", proc_count, 8'd0);
        check("wrap_done_total", 32'(done_cnt), 32'd256);
        check("wrap_overflow", overflow, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/process_stream_ctrl.md
PROCESS_STREAM_CTRL -- requirements
Module: process_stream_ctrl

Interface
REQ-001 Parameter: FIFO_DEPTH, default 4, input sample FIFO depth (power of two, at least 2).
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 sample_in  input  8  sample from pin side.
REQ-005 sample_strobe  input  1  one-cycle push of sample_in.
REQ-006 clear_flags  input  1  clears sticky overflow.
REQ-007 sample_out  output  8  last kernel result, registered.
REQ-008 out_strobe  output  1  one-cycle pulse: sample_out updated.
REQ-009 busy  output  1  high when FSM is not IDLE or FIFO is non-empty.
REQ-010 overflow  output  1  sticky: a strobed sample was dropped.
REQ-011 proc_count  output  8  completed-sample counter, wraps 255->0.
REQ-012 k_in0  output  8  data to kernel in0; equals FIFO head.
REQ-013 k_in0_valid / k_in0_ready  output / input  1 / 1  kernel in0 handshake.
REQ-014 k_start_valid / k_start_ready  output / input  1 / 1  kernel start token.
REQ-015 k_out0  input  8  kernel result data.
REQ-016 k_out0_valid / k_out0_ready  input / output  1 / 1  kernel result handshake.
REQ-017 k_end_valid / k_end_ready  input / output  1 / 1  kernel end token.

Function
REQ-018 Handshake: a transfer occurs on an edge where valid and ready are both high; an asserted valid SHALL stay high with stable data until that transfer.
REQ-019 FIFO push on sample_strobe if not full, or if a pop occurs in the same cycle; otherwise the sample is dropped and overflow is set.
REQ-020 FIFO pop on the k_in0 transfer only; occupancy SHALL be unchanged by a simultaneous push and pop.
REQ-021 Pointers SHALL wrap modulo FIFO_DEPTH; full and empty SHALL be distinguished by a separate occupancy count of 0..FIFO_DEPTH.
REQ-022 FSM states: IDLE, ISSUE, WAIT.
REQ-023 IDLE -> ISSUE when the FIFO is non-empty; the in0_done and start_done flags SHALL clear on this transition.
REQ-024 ISSUE: k_in0_valid = !in0_done and k_start_valid = !start_done; each flag SHALL set on its own transfer, in either order or together.
REQ-025 ISSUE -> WAIT on the edge where both transfers have completed, including both completing on the same edge; out0_done and end_done SHALL clear on this transition.
REQ-026 WAIT: k_out0_ready = !out0_done and k_end_ready = !end_done; k_out0 SHALL be captured into a result register on its transfer.
REQ-027 WAIT -> IDLE on the edge completing the last of the out0 and end transfers; on that edge sample_out SHALL load the captured result (or k_out0 if it arrives on the same edge) and proc_count SHALL increment.
REQ-028 out_strobe SHALL be high for exactly the one cycle after that edge.
REQ-029 Latency: a strobe into an empty FIFO with the FSM idle in cycle N SHALL give k_in0_valid high in cycle N+2.
REQ-030 k_in0_valid, k_start_valid, k_out0_ready and k_end_ready SHALL be low in IDLE; the ready outputs SHALL also be low in ISSUE.
REQ-031 clear_flags SHALL clear overflow; if an overflow event occurs in the same cycle, overflow SHALL be set (set has priority).

Reset
REQ-032 On rst: FSM = IDLE, FIFO empty, all done flags cleared, result register = 0.
REQ-033 On rst: sample_out = 0, out_strobe = 0, overflow = 0, proc_count = 0, all kernel valid/ready outputs = 0.
REQ-034 rst asserted mid-operation SHALL abort the transaction, discard FIFO contents, and take priority over all other inputs.

Verification
REQ-035 Single sample: strobe 0x40, kernel always ready, kernel returns 0x3A with end -> k_in0_valid in cycle N+2, then sample_out=0x3A, one out_strobe pulse, proc_count=1.
REQ-036 Handshake skew: start_ready held low 5 cycles after in0 is accepted, end_valid arriving 3 cycles after out0 -> no duplicate transfer, exactly one out_strobe, FIFO popped once.
REQ-037 Overflow: kernel stalled (in0_ready=0), 5 strobes 0x01..0x05 with depth 4 -> overflow=1, FIFO holds 0x01..0x04, outputs later appear in that order; clear_flags -> overflow=0.
REQ-038 Simultaneous events: FIFO full, strobe on the same edge as the k_in0 transfer -> sample accepted, occupancy stays 4, overflow stays 0.
REQ-039 Wrap: 256 completed samples -> proc_count returns to 0; FIFO pointers wrap with no data loss (check against a scoreboard).
REQ-040 Reset in WAIT: rst pulsed while out0 is pending -> all outputs at reset values next cycle, busy=0, and a later new strobe is processed normally.
